// File: rtl/pad_pkg.sv
// Shared constants and small helpers for the ioif pad bridge and the ioif null drivers.
package pad_pkg;

   localparam logic IOIF_PO_RST = 1'b1;
   localparam logic IOIF_OE_RST = 1'b0;
   localparam logic IOIF_PU_RST = 1'b1;
   localparam logic IOIF_PI_RST = 1'b1;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'd0,
      EDGE_RISE = 2'd1,
      EDGE_FALL = 2'd2
   } edge_e;

   // Sticky flag update where a new set beats a simultaneous clear.
   function automatic logic next_flag(input logic flag, input logic set, input logic clr);
      return set | (flag & ~clr);
   endfunction

endpackage

// File: rtl/ioif.sv
// Controller-to-pad channel; the load modport is the pad-side endpoint.
interface ioif;
   logic po;
   logic oe;
   logic pu;
   logic pi;

   modport load (input po, input oe, input pu, output pi);
   modport ctrl (output po, output oe, output pu, input pi);
endinterface

// File: rtl/ioif_pin_filt.sv
// One pad input: synchronizer, optional glitch filter (IOIF_PAD_FILTER_EN), edge detect, pending flag.
module ioif_pin_filt
   import pad_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              pad_pi,
   input  logic [FILT_W-1:0] filt_len,
   input  logic              rise_en,
   input  logic              fall_en,
   input  logic              clr,
   output logic              pi,
   output logic              pend
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   s_s;
   logic                   f_r;
   logic                   upd_s;
   edge_e                  evt_r;
   edge_e                  evt_nxt_s;
   logic                   set_s;
   logic                   pend_r;

   // Synchronizer chain; the oldest stage is the synchronized pin value.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_r <= {SYNC_STAGES{IOIF_PI_RST}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], pad_pi};
      end
   end

   assign s_s = sync_r[SYNC_STAGES-1];

`ifdef IOIF_PAD_FILTER_EN
   logic [FILT_W-1:0] cnt_r;
   logic [FILT_W-1:0] cnt_nxt_s;

   // Count cycles of disagreement; >= keeps a lowered threshold safe mid-count.
   always_comb begin
      cnt_nxt_s = '0;
      upd_s     = 1'b0;
      if (s_s == f_r) begin
         cnt_nxt_s = '0;
      end else if (cnt_r >= filt_len) begin
         upd_s     = 1'b1;
         cnt_nxt_s = '0;
      end else if (cnt_r != '1) begin
         cnt_nxt_s = cnt_r + FILT_W'(1);
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Filter counter register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end
`else
   logic unused_filt_s;
   assign unused_filt_s = ^filt_len;
   assign upd_s         = (s_s != f_r);
`endif

   // Filtered pin value.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         f_r <= IOIF_PI_RST;
      end else if (upd_s) begin
         f_r <= s_s;
      end else begin
         f_r <= f_r;
      end
   end

   // Classify an update event by the new filtered level.
   always_comb begin
      evt_nxt_s = EDGE_NONE;
      if (upd_s) begin
         case (s_s)
            1'b1:    evt_nxt_s = EDGE_RISE;
            1'b0:    evt_nxt_s = EDGE_FALL;
            default: evt_nxt_s = EDGE_NONE;
         endcase
      end else begin
         evt_nxt_s = EDGE_NONE;
      end
   end

   // Edge event register, consumed by the pending flag one cycle later.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         evt_r <= EDGE_NONE;
      end else begin
         evt_r <= evt_nxt_s;
      end
   end

   assign set_s = ((evt_r == EDGE_RISE) && rise_en) || ((evt_r == EDGE_FALL) && fall_en);

   // Sticky pending flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_r <= 1'b0;
      end else begin
         pend_r <= next_flag(pend_r, set_s, clr);
      end
   end

   assign pi   = f_r;
   assign pend = pend_r;

endmodule

// File: rtl/ioif_pad_bridge.sv
// Load-side ioif endpoint: registered pad outputs, filtered pad inputs with sticky edge interrupts.
// Glitch filter is compiled in when IOIF_PAD_FILTER_EN is defined.
module ioif_pad_bridge
   import pad_pkg::*;
#(
   parameter int IOC         = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 4
) (
   input  logic              clk,
   input  logic              resetn,
   ioif.load                 ioifld [0:IOC-1],
   output logic [IOC-1:0]    pad_po,
   output logic [IOC-1:0]    pad_oe,
   output logic [IOC-1:0]    pad_pu,
   input  logic [IOC-1:0]    pad_pi,
   input  logic [FILT_W-1:0] filt_len,
   input  logic [IOC-1:0]    irq_rise_en,
   input  logic [IOC-1:0]    irq_fall_en,
   input  logic [IOC-1:0]    irq_clr,
   output logic [IOC-1:0]    irq_pend,
   output logic              irq
);

   logic [IOC-1:0] po_s;
   logic [IOC-1:0] oe_s;
   logic [IOC-1:0] pu_s;
   logic [IOC-1:0] pi_s;
   logic [IOC-1:0] pend_s;
   logic [IOC-1:0] pad_po_r;
   logic [IOC-1:0] pad_oe_r;
   logic [IOC-1:0] pad_pu_r;

   for (genvar i = 0; i < IOC; i++) begin : g_pin
      assign po_s[i]       = ioifld[i].po;
      assign oe_s[i]       = ioifld[i].oe;
      assign pu_s[i]       = ioifld[i].pu;
      assign ioifld[i].pi  = pi_s[i];

      ioif_pin_filt #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_W      (FILT_W)
      ) u_filt (
         .clk      (clk),
         .resetn   (resetn),
         .pad_pi   (pad_pi[i]),
         .filt_len (filt_len),
         .rise_en  (irq_rise_en[i]),
         .fall_en  (irq_fall_en[i]),
         .clr      (irq_clr[i]),
         .pi       (pi_s[i]),
         .pend     (pend_s[i])
      );
   end

   // Output registers toward the pad ring; reset matches the null-driver defaults.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pad_po_r <= {IOC{IOIF_PO_RST}};
         pad_oe_r <= {IOC{IOIF_OE_RST}};
         pad_pu_r <= {IOC{IOIF_PU_RST}};
      end else begin
         pad_po_r <= po_s;
         pad_oe_r <= oe_s;
         pad_pu_r <= pu_s;
      end
   end

   assign pad_po   = pad_po_r;
   assign pad_oe   = pad_oe_r;
   assign pad_pu   = pad_pu_r;
   assign irq_pend = pend_s;
   assign irq      = |pend_s;

endmodule

// File: tb/tb_ioif_pad_bridge.sv
// Scoreboard bench for ioif_pad_bridge with a cycle-level reference model of the pad rules.
module tb_ioif_pad_bridge;

   localparam int IOC = 16;
   localparam int SS  = 2;
   localparam int FW  = 4;

   typedef struct packed {
      logic [IOC-1:0] po;
      logic [IOC-1:0] oe;
      logic [IOC-1:0] pu;
      logic [IOC-1:0] pi;
      logic [IOC-1:0] pend;
   } snap_t;

   logic            clk = 1'b0;
   logic            resetn;
   logic [IOC-1:0]  po_v, oe_v, pu_v, pi_v;
   logic [IOC-1:0]  pad_po, pad_oe, pad_pu, pad_pi;
   logic [FW-1:0]   filt_len;
   logic [IOC-1:0]  irq_rise_en, irq_fall_en, irq_clr, irq_pend;
   logic            irq;

   int n_checks = 0;
   int n_fail   = 0;

   ioif ifc [0:IOC-1] ();

   for (genvar g = 0; g < IOC; g++) begin : g_ifc
      assign ifc[g].po = po_v[g];
      assign ifc[g].oe = oe_v[g];
      assign ifc[g].pu = pu_v[g];
      assign pi_v[g]   = ifc[g].pi;
   end

   ioif_pad_bridge #(.IOC(IOC), .SYNC_STAGES(SS), .FILT_W(FW)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .ioifld      (ifc),
      .pad_po      (pad_po),
      .pad_oe      (pad_oe),
      .pad_pu      (pad_pu),
      .pad_pi      (pad_pi),
      .filt_len    (filt_len),
      .irq_rise_en (irq_rise_en),
      .irq_fall_en (irq_fall_en),
      .irq_clr     (irq_clr),
      .irq_pend    (irq_pend),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   // Reference model state
   snap_t          exp_q[$];
   logic [IOC-1:0] pad_hist[$];
   logic [IOC-1:0] m_po, m_oe, m_pu, m_f, m_pend, m_rise, m_fall;
   int             m_run[IOC];

   function automatic snap_t reset_snap();
      snap_t r;
      r.po = '1; r.oe = '0; r.pu = '1; r.pi = '1; r.pend = '0;
      return r;
   endfunction

   task automatic model_reset();
      pad_hist.delete();
      for (int k = 0; k < SS; k++) pad_hist.push_back('1);
      m_po = '1; m_oe = '0; m_pu = '1; m_f = '1; m_pend = '0;
      m_rise = '0; m_fall = '0;
      for (int k = 0; k < IOC; k++) m_run[k] = 0;
   endtask

   // Advance the model one clock and queue what the DUT must show afterwards.
   always @(posedge clk) begin : model
      snap_t          e;
      logic [IOC-1:0] s, nrise, nfall;
      int             lim;
      if (!resetn) begin
         model_reset();
      end else begin
`ifdef IOIF_PAD_FILTER_EN
         lim = int'(filt_len);
`else
         lim = 0;
`endif
         m_pend = (m_pend & ~irq_clr) | (m_rise & irq_rise_en) | (m_fall & irq_fall_en);
         s = pad_hist.pop_front();
         pad_hist.push_back(pad_pi);
         nrise = '0;
         nfall = '0;
         for (int i = 0; i < IOC; i++) begin
            if (s[i] != m_f[i]) begin
               if (m_run[i] >= lim) begin
                  m_f[i]   = s[i];
                  m_run[i] = 0;
                  if (s[i]) nrise[i] = 1'b1;
                  else      nfall[i] = 1'b1;
               end else begin
                  m_run[i]++;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_rise = nrise;
         m_fall = nfall;
         m_po = po_v; m_oe = oe_v; m_pu = pu_v;
      end
      e.po = m_po; e.oe = m_oe; e.pu = m_pu; e.pi = m_f; e.pend = m_pend;
      exp_q.push_back(e);
   end

   task automatic check(input string name, input logic [IOC-1:0] got, input logic [IOC-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   // Monitor: pop one expectation per cycle, reset values win while resetn is low.
   always @(negedge clk) begin : monitor
      snap_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
      end else begin
         e = exp_q.pop_front();
         if (!resetn) e = reset_snap();
         check("pad_po",   pad_po,   e.po);
         check("pad_oe",   pad_oe,   e.oe);
         check("pad_pu",   pad_pu,   e.pu);
         check("pi",       pi_v,     e.pi);
         check("irq_pend", irq_pend, e.pend);
         check("irq",      {{(IOC-1){1'b0}}, irq}, {{(IOC-1){1'b0}}, |e.pend});
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      resetn = 1'b0;
      po_v = '1; oe_v = '0; pu_v = '1; pad_pi = '1;
      filt_len = 4'd3; irq_rise_en = '0; irq_fall_en = '0; irq_clr = '0;

      // Reset held: all inputs toggle, outputs must stay at reset values
      for (int c = 0; c < 5; c++) begin
         po_v = IOC'($urandom); oe_v = IOC'($urandom); pu_v = IOC'($urandom);
         pad_pi = IOC'($urandom); irq_rise_en = '1; irq_fall_en = '1;
         irq_clr = IOC'($urandom);
         step(1);
      end
      po_v = '1; oe_v = '0; pu_v = '1; pad_pi = '1;
      irq_rise_en = '0; irq_fall_en = '0; irq_clr = '0;
      resetn = 1'b1;
      step(3);

      // Output path on pin 3
      po_v[3] = 1'b0; oe_v[3] = 1'b1;
      step(3);

      // Filtered falling edge on pin 5
      irq_fall_en[5] = 1'b1;
      pad_pi[5] = 1'b0;
      step(10);

      // Glitch reject then pass on pin 0
      pad_pi[0] = 1'b0; step(3); pad_pi[0] = 1'b1; step(10);
      pad_pi[0] = 1'b0; step(4); pad_pi[0] = 1'b1; step(12);

      // Set/clear collision on pin 7
      pad_pi[7] = 1'b0; step(12);
      irq_rise_en[7] = 1'b1;
      pad_pi[7] = 1'b1;
`ifdef IOIF_PAD_FILTER_EN
      step(SS + 3 + 1);
`else
      step(SS + 1);
`endif
      irq_clr[7] = 1'b1; step(1); irq_clr[7] = 1'b0;
      step(4);
      irq_clr[7] = 1'b1; step(1); irq_clr[7] = 1'b0;
      step(3);

      // Disabled edges: pi follows, no pending
      irq_rise_en = '0; irq_fall_en = '0;
      irq_clr = '1; step(1); irq_clr = '0;
      pad_pi = ~pad_pi; step(10);
      pad_pi = ~pad_pi; step(10);

      // Mid-count reset on pin 2
      filt_len = 4'd15; pad_pi = '1; step(25);
      pad_pi[2] = 1'b0; step(10);
      resetn = 1'b0; step(1); resetn = 1'b1;
      step(25);

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         if (c % 150 == 0) filt_len = FW'($urandom_range(5));
         po_v = IOC'($urandom); oe_v = IOC'($urandom); pu_v = IOC'($urandom);
         for (int i = 0; i < IOC; i++) begin
            if ($urandom_range(7) == 0) pad_pi[i] = ~pad_pi[i];
            irq_clr[i] = ($urandom_range(15) == 0);
         end
         if (c % 40 == 0) begin
            irq_rise_en = IOC'($urandom);
            irq_fall_en = IOC'($urandom);
         end
         resetn = ($urandom_range(99) != 0);
         step(1);
         resetn = 1'b1;
      end
      irq_clr = '0;
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
